shiftreg_xfer: RTL
==================

Name: shiftreg_xfer

Overview:
- Parametrised, handshaked serial/parallel shift engine; next generation of the single-word SPI master shift register.
- Accepts a parallel word over a val/rdy interface and shifts it out one bit per `shift_en` strobe while shifting `sin` in.
- Per-transaction length (1..nbits) and bit order (MSB-first or LSB-first).
- Returns the received word, right-aligned, over a second val/rdy interface; sits between the SPI master FSM and its request/response queues.

Parameters:
- nbits, 32, maximum transfer width in bits (>= 2)

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- load_val  input  1  load request valid
- load_rdy  output  1  engine can accept a load
- load_data  input  nbits  word to transmit; only bits [len-1:0] are used
- load_len  input  $clog2(nbits)+1  transfer length; 0 or >nbits means nbits
- load_lsb_first  input  1  1 = LSB first, 0 = MSB first
- shift_en  input  1  one-cycle strobe: sample `sin` and advance one bit
- sin  input  1  serial data in
- sout  output  1  serial data out (current bit)
- busy  output  1  transfer in progress (SHIFT state)
- recv_val  output  1  received word valid
- recv_rdy  input  1  consumer accepts received word
- recv_data  output  nbits  received word, right-aligned, upper bits zero

Behaviour:
- Internal state:
  - `regval[nbits-1:0]`
  - down-counter `cnt`
  - `len_q`
  - `lsb_q`
  - FSM `state` in {IDLE, SHIFT, DONE}
- Reset:
  - Values: state=IDLE, regval=0, cnt=0, len_q=0, lsb_q=0.
  - Resulting outputs: load_rdy=1, busy=0, recv_val=0, sout=0, recv_data=0.
  - Reset has priority over every other input and aborts any transfer mid-operation; no recv_val is produced for an aborted transfer.
- Outputs are decoded from registered state only (no combinational input-to-output path):
  - load_rdy = (state==IDLE)
  - busy = (state==SHIFT)
  - recv_val = (state==DONE)
- sout = regval[nbits-1] when lsb_q=0, else regval[0].
- IDLE, on load_val & load_rdy:
  - L = effective length; cnt <= L; lsb_q <= load_lsb_first; len_q <= L.
  - Masked data m = load_data & ((1<<L)-1).
  - MSB-first: regval <= m << (nbits-L), i.e. left-aligned. LSB-first: regval <= m.
  - Next state SHIFT; the first bit appears on sout the cycle after the load handshake.
- SHIFT, on shift_en:
  - MSB-first: regval <= {regval[nbits-2:0], sin}. LSB-first: regval <= {sin, regval[nbits-1:1]}.
  - cnt <= cnt-1; when cnt==1 at the strobe, next state is DONE.
  - A SHIFT with no shift_en holds all state.
- Received alignment after L shifts:
  - MSB-first: the received word is already in regval[L-1:0], upper bits zero.
  - LSB-first: the received word is in regval[nbits-1:nbits-L]; recv_data = regval >> (nbits-L).
  - recv_data is combinational from regval/len_q/lsb_q and is stable for the whole time DONE is held.
- DONE:
  - recv_val=1; on recv_rdy, go to IDLE. load_rdy is 0 in DONE, so a back-to-back load needs one IDLE cycle.
- Ignored inputs:
  - shift_en is ignored in IDLE and DONE.
  - load_val is ignored in SHIFT and DONE.
- Latency: load handshake -> first sout bit 1 cycle; last shift_en -> recv_val 1 cycle.

Decomposition:
- Package shiftreg_xfer_pkg:
  - state enum (IDLE, SHIFT, DONE)
  - length-width localparam helper
- No sub-module needed. The shift datapath stays inline; alignment and masking are a small combinational function in the package.

Test Plan (nbits=8):
- MSB-first, load_data=8'hA5, len=8; sin bits 0,0,1,1,1,1,0,0 on 8 strobes -> sout sequence 1,0,1,0,0,1,0,1; recv_val=1 with recv_data=8'h3C one cycle after the 8th strobe.
- LSB-first, load_data=8'h1E, len=8; sin=1 then seven 0s -> sout 0,1,1,1,1,0,0,0; recv_data=8'h01.
- MSB-first, load_data=8'hFD, len=3; sin 1,1,0 -> sout 1,0,1; recv_data=8'h06; recv_val after exactly 3 strobes.
- Backpressure: recv_rdy=0 for 5 cycles while shift_en toggles and load_val=1 -> recv_data unchanged, load_rdy=0, no state change; recv_rdy=1 -> IDLE next cycle, load_rdy=1.
- Reset mid-transfer after 3 of 8 strobes -> next cycle state IDLE, load_rdy=1, busy=0, sout=0, recv_val never asserted.
- load_len=0 and load_len=9 -> each behaves as len=8 (8 strobes to DONE); shift_en pulses in IDLE before the load leave regval=0.

Source files
------------

// File: rtl/shiftreg_xfer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shiftreg_xfer_pkg
//  Brief    : Shared state encoding and sizing helper for the shift engine.
//  Revision : 1.0 - initial release
// ============================================================================
package shiftreg_xfer_pkg;

    // Transfer FSM encoding; two bits cover the three states.
    localparam logic [1:0] c_state_idle  = 2'd0;
    localparam logic [1:0] c_state_shift = 2'd1;
    localparam logic [1:0] c_state_done  = 2'd2;

    // Width of a length field able to hold every value 0..n inclusive.
    function automatic int len_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shiftreg_xfer.sv
`default_nettype none
// ============================================================================
//  Module   : shiftreg_xfer
//  Brief    : Handshaked serial/parallel shift engine with per-transfer
//             length and bit order. Loads a word over val/rdy, shifts it out
//             on shift_en strobes while capturing sin, and returns the
//             received word right-aligned over a second val/rdy interface.
//  Revision : 1.0 - initial release
// ============================================================================
module shiftreg_xfer
    import shiftreg_xfer_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_val,
    output logic                          load_rdy,
    input  logic [NBITS-1:0]              load_data,
    input  logic [len_width(NBITS)-1:0]   load_len,
    input  logic                          load_lsb_first,
    input  logic                          shift_en,
    input  logic                          sin,
    output logic                          sout,
    output logic                          busy,
    output logic                          recv_val,
    input  logic                          recv_rdy,
    output logic [NBITS-1:0]              recv_data
);

    localparam int LW = len_width(NBITS);
    localparam logic [LW-1:0] c_nbits_len = LW'(NBITS);

    logic [1:0]       r_state;
    logic [NBITS-1:0] r_regval;
    logic [LW-1:0]    r_cnt;
    logic [LW-1:0]    r_len;
    logic             r_lsb;

    logic [LW-1:0]    w_len;
    logic [NBITS-1:0] w_mask;
    logic [NBITS-1:0] w_load_word;

    // Effective length, masked payload and its start alignment for a load.
    always_comb begin
        w_len       = load_len;
        w_mask      = '0;
        w_load_word = '0;
        if ((load_len == '0) || (load_len > c_nbits_len)) begin
            w_len = c_nbits_len;
        end
        // A full-width length shifts every one out, leaving an all-ones mask.
        w_mask = ~({NBITS{1'b1}} << w_len);
        if (load_lsb_first) begin
            w_load_word = load_data & w_mask;
        end else begin
            w_load_word = (load_data & w_mask) << (c_nbits_len - w_len);
        end
    end

    // Transfer FSM together with the shift register, counter and settings.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_state_idle;
            r_regval <= '0;
            r_cnt    <= '0;
            r_len    <= '0;
            r_lsb    <= 1'b0;
        end else begin
            case (r_state)
                c_state_idle: begin
                    if (load_val) begin
                        r_regval <= w_load_word;
                        r_cnt    <= w_len;
                        r_len    <= w_len;
                        r_lsb    <= load_lsb_first;
                        r_state  <= c_state_shift;
                    end
                end
                c_state_shift: begin
                    if (shift_en) begin
                        if (r_lsb) begin
                            r_regval <= {sin, r_regval[NBITS-1:1]};
                        end else begin
                            r_regval <= {r_regval[NBITS-2:0], sin};
                        end
                        r_cnt <= r_cnt - LW'(1);
                        if (r_cnt == LW'(1)) begin
                            r_state <= c_state_done;
                        end
                    end
                end
                c_state_done: begin
                    if (recv_rdy) begin
                        r_state <= c_state_idle;
                    end
                end
                default: begin
                    r_state <= c_state_idle;
                end
            endcase
        end
    end

    // Handshake and serial outputs come from registered state only.
    always_comb begin
        load_rdy = (r_state == c_state_idle);
        busy     = (r_state == c_state_shift);
        recv_val = (r_state == c_state_done);
        sout     = r_lsb ? r_regval[0] : r_regval[NBITS-1];
    end

    // LSB-first data lands in the top len bits; MSB-first is already aligned.
    always_comb begin
        if (r_lsb) begin
            recv_data = r_regval >> (c_nbits_len - r_len);
        end else begin
            recv_data = r_regval;
        end
    end

endmodule
`default_nettype wire
